// File: rtl/poly_op_seq_if.sv
// Request/status bundle between the Kyber controller and the poly-op sequencer.
// The master side issues start/op/abort; the slave (sequencer) returns the
// address-generator drive (mode, clk_counter), read/write enables and status.
interface poly_op_seq_if;
    logic       start;
    logic [1:0] op;
    logic       abort;
    logic [1:0] mode;
    logic [7:0] clk_counter;
    logic       rd_en;
    logic       wr_en;
    logic       busy;
    logic       done;

    modport master (
        output start, op, abort,
        input  mode, clk_counter, rd_en, wr_en, busy, done
    );

    modport slave (
        input  start, op, abort,
        output mode, clk_counter, rd_en, wr_en, busy, done
    );
endinterface

// File: rtl/poly_op_seq.sv
// Operation sequencer for the polynomial address generator / butterfly datapath.
// One request at a time: IDLE -> RUN (reads issued) -> DRAIN (write pipeline
// empties) -> DONE (one-cycle pulse) -> IDLE. The step counter runs straight
// through RUN and DRAIN so the address generator sees one continuous count.
module poly_op_seq #(
    parameter int NTT_ISSUE    = 224,
    parameter int MULT_ISSUE   = 128,
    parameter int ADDSUB_ISSUE = 64,
    parameter int NTT_DRAIN    = 10,
    parameter int MULT_DRAIN   = 18,
    parameter int ADDSUB_DRAIN = 6
) (
    input  logic          clk,
    input  logic          rst,
    poly_op_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // NTT and INVNTT share lengths, so only the two other codes are named.
    localparam logic [1:0] OP_MULT   = 2'd2;
    localparam logic [1:0] OP_ADDSUB = 2'd3;

    // Number of read-issue cycles for an operation code.
    function automatic logic [7:0] issue_len(input logic [1:0] m);
        logic [7:0] n;
        case (m)
            OP_MULT:   n = 8'(MULT_ISSUE);
            OP_ADDSUB: n = 8'(ADDSUB_ISSUE);
            default:   n = 8'(NTT_ISSUE);
        endcase
        return n;
    endfunction

    // Write-pipeline depth for an operation code; also the first count at
    // which a valid write address emerges.
    function automatic logic [7:0] drain_len(input logic [1:0] m);
        logic [7:0] n;
        case (m)
            OP_MULT:   n = 8'(MULT_DRAIN);
            OP_ADDSUB: n = 8'(ADDSUB_DRAIN);
            default:   n = 8'(NTT_DRAIN);
        endcase
        return n;
    endfunction

    // Last count of an operation (ISSUE + DRAIN - 1); the counter parks here.
    function automatic logic [7:0] final_cnt(input logic [1:0] m);
        return issue_len(m) + drain_len(m) - 8'd1;
    endfunction

    state_e     state_q, state_d;
    logic [1:0] mode_q,  mode_d;
    logic [7:0] cnt_q,   cnt_d;
    logic       rd_en_q, rd_en_d;
    logic       wr_en_q, wr_en_d;
    logic       busy_q,  busy_d;
    logic       done_q,  done_d;

    // Next-state, counter and output decode; outputs are computed from the
    // next state so they come straight out of flops.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    mode_d  = bus.op;
                    cnt_d   = 8'd0;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == issue_len(mode_q) - 8'd1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Abort beats the final-count transition.
                if (bus.abort) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q == final_cnt(mode_q)) begin
                    // Counter holds its final value through DONE and IDLE.
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                // DONE lasts exactly one cycle.
                state_d = IDLE;
            end
        endcase

        rd_en_d = (state_d == RUN);
        busy_d  = (state_d == RUN) || (state_d == DRAIN);
        done_d  = (state_d == DONE);
        // Writes track the write-address pipeline: valid from DRAIN counts
        // after the first read until the final count.
        wr_en_d = busy_d && (cnt_d >= drain_len(mode_d)) && (cnt_d <= final_cnt(mode_d));
    end

    // State and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 2'd0;
            cnt_q   <= 8'd0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            rd_en_q <= rd_en_d;
            wr_en_q <= wr_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.mode        = mode_q;
    assign bus.clk_counter = cnt_q;
    assign bus.rd_en       = rd_en_q;
    assign bus.wr_en       = wr_en_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_poly_op_seq.sv
// Scoreboard bench for poly_op_seq: stimulus pushes the expected profile of
// each operation that should complete; an independent monitor gathers the
// observed profile of every busy window and checks it when done pulses.
module tb_poly_op_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    poly_op_seq_if bus();

    poly_op_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int op;
        int issue;
        int drain;
        int t0;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   stray    = 0;

    // Operation lengths straight from the operation table.
    function automatic int issue_of(input int op);
        if (op == 2) return 128;
        if (op == 3) return 64;
        return 224;
    endfunction

    function automatic int drain_of(input int op);
        if (op == 2) return 18;
        if (op == 3) return 6;
        return 10;
    endfunction

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: event not expected at cycle %0d", name, cyc);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: per busy window, collect read/write counts and count ranges,
    // then compare against the scoreboard head when done appears.
    initial begin
        int   prev_busy, prev_done, prev_cnt;
        int   busy_cnt, rd_cnt, rd_min, rd_max, wr_cnt, wr_min, wr_max;
        int   mode0, mode_chg, step_err, c;
        exp_t e;
        prev_busy = 0; prev_done = 0; prev_cnt = 0;
        busy_cnt = 0; rd_cnt = 0; rd_min = 999; rd_max = -1;
        wr_cnt = 0; wr_min = 999; wr_max = -1;
        mode0 = 0; mode_chg = 0; step_err = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_busy = 0;
                prev_done = 0;
                continue;
            end
            c = int'(bus.clk_counter);
            if (!bus.busy && (bus.rd_en || bus.wr_en)) stray++;
            if (bus.busy && !prev_busy) begin
                busy_cnt = 0; rd_cnt = 0; rd_min = 999; rd_max = -1;
                wr_cnt = 0; wr_min = 999; wr_max = -1;
                mode0 = int'(bus.mode); mode_chg = 0; step_err = 0;
                if (c != 0) step_err++;
            end
            if (bus.busy) begin
                busy_cnt++;
                if (prev_busy && c != prev_cnt + 1) step_err++;
                if (int'(bus.mode) != mode0) mode_chg++;
                if (bus.rd_en) begin
                    rd_cnt++;
                    if (c < rd_min) rd_min = c;
                    if (c > rd_max) rd_max = c;
                end
                if (bus.wr_en) begin
                    wr_cnt++;
                    if (c < wr_min) wr_min = c;
                    if (c > wr_max) wr_max = c;
                end
            end
            if (bus.done) begin
                if (prev_done) fail_now("done_double_pulse");
                else if (exp_q.size() == 0) fail_now("unexpected_done");
                else begin
                    e = exp_q.pop_front();
                    check("done_after_busy", prev_busy, 1);
                    check("done_mode", int'(bus.mode), e.op);
                    check("done_latency", cyc - e.t0, e.issue + e.drain + 1);
                    check("final_count", c, e.issue + e.drain - 1);
                    check("busy_cycles", busy_cnt, e.issue + e.drain);
                    check("rd_cycles", rd_cnt, e.issue);
                    check("rd_first_cnt", rd_min, 0);
                    check("rd_last_cnt", rd_max, e.issue - 1);
                    check("wr_cycles", wr_cnt, e.issue);
                    check("wr_first_cnt", wr_min, e.drain);
                    check("wr_last_cnt", wr_max, e.issue + e.drain - 1);
                    check("mode_stable", mode_chg, 0);
                    check("count_step", step_err, 0);
                    check("idle_at_done", int'({bus.busy, bus.rd_en, bus.wr_en}), 0);
                end
            end
            prev_busy = bus.busy;
            prev_done = bus.done;
            prev_cnt  = c;
        end
    end

    // Drive a start pulse at the current negedge; returns at the next negedge.
    task automatic issue_op(input int op, input bit completes);
        exp_t e;
        bus.start = 1'b1;
        bus.op    = 2'(op);
        if (completes) begin
            e.op = op; e.issue = issue_of(op); e.drain = drain_of(op); e.t0 = cyc;
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) fail_now("done_timeout");
    endtask

    task automatic wait_cnt(input int n);
        bit seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.busy && int'(bus.clk_counter) == n) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) fail_now("count_wait_timeout");
    endtask

    task automatic abort_pulse(input string name);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check({name, "_cnt"}, int'(bus.clk_counter), 0);
        check({name, "_busy_rd_wr_done"}, int'({bus.busy, bus.rd_en, bus.wr_en, bus.done}), 0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_mode"}, int'(bus.mode), 0);
        check({name, "_cnt"}, int'(bus.clk_counter), 0);
        check({name, "_rd_wr_busy_done"}, int'({bus.rd_en, bus.wr_en, bus.busy, bus.done}), 0);
    endtask

    initial begin
        int op, kind, n;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.abort = 1'b0;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // NTT, with abort asserted during DONE (must be ignored).
        issue_op(0, 1'b1);
        check("ntt_start_cnt", int'(bus.clk_counter), 0);
        check("ntt_start_rd_busy", int'({bus.rd_en, bus.busy}), 3);
        wait_done();
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("ntt_hold_cnt", int'(bus.clk_counter), 233);
        check("ntt_idle_busy_done", int'({bus.busy, bus.done}), 0);

        // MULT, with a start during DONE (must be ignored).
        issue_op(2, 1'b1);
        check("mult_mode", int'(bus.mode), 2);
        wait_done();
        bus.start = 1'b1;
        bus.op    = 2'd1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("start_in_done_ignored", int'(bus.busy), 0);
        check("start_in_done_mode", int'(bus.mode), 2);

        // ADDSUB with a stray start in RUN, then back-to-back INVNTT.
        issue_op(3, 1'b1);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'd1;
        @(negedge clk);
        bus.start = 1'b0;
        check("stray_start_mode", int'(bus.mode), 3);
        wait_done();
        @(negedge clk);
        issue_op(1, 1'b1);
        check("b2b_mode", int'(bus.mode), 1);
        check("b2b_busy", int'(bus.busy), 1);
        wait_done();
        @(negedge clk);

        // INVNTT aborted at count 100.
        issue_op(1, 1'b0);
        wait_cnt(100);
        abort_pulse("abort100");
        repeat (4) @(negedge clk);

        // MULT started with abort high in IDLE (ignored), then async reset
        // mid-DRAIN.
        bus.abort = 1'b1;
        issue_op(2, 1'b0);
        bus.abort = 1'b0;
        check("abort_in_idle_busy", int'(bus.busy), 1);
        wait_cnt(140);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue_op(0, 1'b1);
        wait_done();
        @(negedge clk);

        // ADDSUB with abort on the final count.
        issue_op(3, 1'b0);
        wait_cnt(69);
        abort_pulse("abort_final");
        repeat (4) @(negedge clk);

        // Randomized mix: plain runs, stray starts, aborts at random counts.
        for (int i = 0; i < 12; i++) begin
            op   = int'($urandom_range(0, 3));
            kind = int'($urandom_range(0, 2));
            if (kind == 2) begin
                n = int'($urandom_range(0, issue_of(op) + drain_of(op) - 1));
                issue_op(op, 1'b0);
                wait_cnt(n);
                abort_pulse("rand_abort");
            end else begin
                issue_op(op, 1'b1);
                if (kind == 1) begin
                    repeat ($urandom_range(1, 50)) @(negedge clk);
                    bus.start = 1'b1;
                    bus.op    = 2'($urandom_range(0, 3));
                    @(negedge clk);
                    bus.start = 1'b0;
                end
                wait_done();
                @(negedge clk);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("enables_outside_busy", stray, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/poly_op_seq.md
# poly_op_seq

Sequencer for the polynomial-arithmetic address generator and butterfly datapath. It accepts one operation request (NTT, INVNTT, MULT or ADDSUB) through a start/done handshake and drives the `mode` and `clk_counter` buses that the address generator decodes. It also produces read/write enables aligned to the address generator's write-address pipeline, plus busy/done status to the top-level Kyber controller.

## Interface
- `NTT_ISSUE`, default 224: read-issue cycles for NTT/INVNTT (7 stages × 32).
- `MULT_ISSUE`, default 128: read-issue cycles for MULT.
- `ADDSUB_ISSUE`, default 64: read-issue cycles for ADDSUB.
- `NTT_DRAIN`, default 10: write-pipeline depth for NTT/INVNTT (matches the 10-entry write-address shift register).
- `MULT_DRAIN`, default 18: cycles from first read to first valid write address in MULT.
- `ADDSUB_DRAIN`, default 6: cycles from first read to first valid write address in ADDSUB.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: request pulse; sampled only in IDLE.
- `op`, input, 2: requested operation. 0=NTT, 1=INVNTT, 2=MULT, 3=ADDSUB. Sampled with `start`.
- `abort`, input, 1: synchronous cancel of a running operation.
- `mode`, output, 2: registered operation code to the address generator.
- `clk_counter`, output, 8: registered step counter to the address generator.
- `rd_en`, output, 1: coefficient/twiddle read enable.
- `wr_en`, output, 1: result write enable.
- `busy`, output, 1: high in RUN and DRAIN.
- `done`, output, 1: one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `start`=1 latches `op` into `mode`, clears `clk_counter` to 0 and moves to RUN.
  - `start` in any other state is ignored (no queueing).
- Issue length and drain length are selected per mode:
  - `ISSUE` = `NTT_ISSUE` for NTT/INVNTT, `MULT_ISSUE` for MULT, `ADDSUB_ISSUE` for ADDSUB.
  - `DRAIN` = the matching `*_DRAIN` parameter.
- RUN:
  - `clk_counter` increments by 1 every cycle.
  - `rd_en` = 1.
  - When `clk_counter` = ISSUE−1, move to DRAIN; the counter keeps incrementing.
- DRAIN:
  - `rd_en` = 0; `clk_counter` keeps incrementing.
  - When `clk_counter` = ISSUE+DRAIN−1, move to DONE.
- `wr_en` is decoded from registered state: 1 iff state ∈ {RUN, DRAIN} and DRAIN ≤ `clk_counter` ≤ ISSUE+DRAIN−1.
- DONE:
  - `done` = 1 for exactly one cycle, then return to IDLE.
  - `clk_counter` holds its final value; `mode` holds the last op until the next start.
- `abort`:
  - In RUN or DRAIN, `abort` returns to IDLE on the next edge.
  - It clears `clk_counter` to 0 and does not assert `done`.
  - In IDLE or DONE, `abort` has no effect.
- Arithmetic: the counter is 8-bit unsigned. Maximum final value is 233 (NTT: 224+10−1), so it never wraps with the default parameters. Parameter sums above 256 are illegal.

## Timing
- Reset values: state=IDLE, `mode`=0, `clk_counter`=0, `rd_en`=0, `wr_en`=0, `busy`=0, `done`=0.
- `start` sampled at edge T → at T+1: state=RUN, `clk_counter`=0, `rd_en`=1, `busy`=1.
- Total busy cycles = ISSUE+DRAIN. `done` is high in the cycle after the last busy cycle.
  - NTT/INVNTT: `done` at T+235.
  - MULT: `done` at T+147.
  - ADDSUB: `done` at T+71.
- The earliest next `start` is accepted in the cycle after `done` (IDLE), so back-to-back ops are separated by one idle cycle.
- `rst` asserted mid-operation forces all outputs to reset values immediately, with no `done`.
- `abort` and the final-count transition in the same cycle: `abort` wins; go to IDLE with no `done`.

## Test plan
- Reset, then `start`=1, `op`=0 → `rd_en` high for 224 cycles (`clk_counter` 0..223). `wr_en` high for `clk_counter` 10..233. `done` pulses once, 235 cycles after start. `clk_counter` holds at 233.
- `op`=2 (MULT) → `rd_en` high for `clk_counter` 0..127, `wr_en` high for 18..145, `done` 147 cycles after start, `mode`=2 throughout.
- `op`=3 (ADDSUB), then a second `start` (`op`=1) asserted during RUN → the second start is ignored and `done` fires once, at T+71. A new start in the cycle after `done` is accepted with `mode`=1.
- `abort` at `clk_counter`=100 during INVNTT → next cycle: IDLE, `clk_counter`=0, `busy`=0, `rd_en`=`wr_en`=0, and no `done` pulse.
- `rst` asserted asynchronously mid-DRAIN of MULT (`clk_counter`=140) → all outputs drop to zero before the next edge. After release, `start`/`op`=0 runs a full NTT normally.
- `abort` coinciding with `clk_counter`=69 in ADDSUB (the final count) → IDLE, with `done` never asserted.
